// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard controller: FSM states,
// register-zero constant, counter width and the source-match helper.
package hazard_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int unsigned COUNTER_WIDTH = 32;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] dst,
                                     input logic [4:0] src,
                                     input logic       uses);
    return uses && (dst == src) && (src != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_control_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_control.sv
// ID-stage hazard unit: load-use and compare-in-ID branch stalls, taken-branch
// IF/ID flush, and saturating stall/flush event counters.
module hazard_control
  import hazard_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4:0]               idRs,
  input  logic [4:0]               idRt,
  input  logic                     idUsesRs,
  input  logic                     idUsesRt,
  input  logic                     idBranch,
  input  logic                     branchTaken,
  input  logic                     exMemRead,
  input  logic                     exRegWrite,
  input  logic [4:0]               exWriteAddress,
  input  logic                     memMemRead,
  input  logic [4:0]               memWriteAddress,
  output logic                     pcWrite,
  output logic                     ifIdWrite,
  output logic                     hazard,
  output logic                     ifIdFlush,
  output logic [COUNTER_WIDTH-1:0] stallCount,
  output logic [COUNTER_WIDTH-1:0] flushCount
);

  state_t r_state;

  logic w_ex_match;
  logic w_mem_match;
  logic w_req1;
  logic w_req2;
  logic w_req;

  assign w_ex_match  = reg_match(exWriteAddress, idRs, idUsesRs)
                     | reg_match(exWriteAddress, idRt, idUsesRt);
  assign w_mem_match = reg_match(memWriteAddress, idRs, idUsesRs)
                     | reg_match(memWriteAddress, idRt, idUsesRt);

  // 1-bubble rules: load-use, branch on ALU result in EX, branch on load in MEM.
  assign w_req1 = (exMemRead && w_ex_match)
                | (idBranch && exRegWrite && !exMemRead && w_ex_match)
                | (idBranch && memMemRead && w_mem_match && !w_ex_match);
  // Branch on a load still in EX needs two bubbles; it dominates the others.
  assign w_req2 = idBranch && exMemRead && w_ex_match;
  assign w_req  = w_req1 || w_req2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      unique case (r_state)
        RUN:     r_state <= w_req2 ? HOLD : RUN;
        HOLD:    r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  // Detection is combinational so the stall takes effect in the same cycle.
  always_comb begin
    pcWrite   = 1'b1;
    ifIdWrite = 1'b1;
    hazard    = 1'b0;
    ifIdFlush = 1'b0;
    if (!reset) begin
      if ((r_state == HOLD) || w_req) begin
        pcWrite   = 1'b0;
        ifIdWrite = 1'b0;
        hazard    = 1'b1;
      end else begin
        ifIdFlush = branchTaken;
      end
    end
  end

  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hazard),
    .count (stallCount)
  );

  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ifIdFlush),
    .count (flushCount)
  );

endmodule

// File: tb/tb_hazard_control.sv
// Directed, table-driven bench for hazard_control plus multi-cycle sequences
// and a narrow sat_counter instance to reach saturation quickly.
module tb_hazard_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  idRs, idRt, exWriteAddress, memWriteAddress;
  logic        idUsesRs, idUsesRt, idBranch, branchTaken;
  logic        exMemRead, exRegWrite, memMemRead;
  logic        pcWrite, ifIdWrite, hazard, ifIdFlush;
  logic [31:0] stallCount, flushCount;

  logic        sc_reset, sc_inc;
  logic [1:0]  sc_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  hazard_control dut (
    .clk             (clk),
    .reset           (reset),
    .idRs            (idRs),
    .idRt            (idRt),
    .idUsesRs        (idUsesRs),
    .idUsesRt        (idUsesRt),
    .idBranch        (idBranch),
    .branchTaken     (branchTaken),
    .exMemRead       (exMemRead),
    .exRegWrite      (exRegWrite),
    .exWriteAddress  (exWriteAddress),
    .memMemRead      (memMemRead),
    .memWriteAddress (memWriteAddress),
    .pcWrite         (pcWrite),
    .ifIdWrite       (ifIdWrite),
    .hazard          (hazard),
    .ifIdFlush       (ifIdFlush),
    .stallCount      (stallCount),
    .flushCount      (flushCount)
  );

  sat_counter #(.WIDTH(2)) u_sc (
    .clk   (clk),
    .reset (sc_reset),
    .inc   (sc_inc),
    .count (sc_count)
  );

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       br;
    logic       bt;
    logic       exmr;
    logic       exrw;
    logic [4:0] exwa;
    logic       memmr;
    logic [4:0] memwa;
  } in_t;

  typedef struct {
    string name;
    in_t   i;
    logic  pc;
    logic  ifid;
    logic  hz;
    logic  fl;
  } vec_t;

  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt,
                             input logic urs, input logic urt,
                             input logic br, input logic bt,
                             input logic exmr, input logic exrw,
                             input logic [4:0] exwa,
                             input logic memmr, input logic [4:0] memwa);
    in_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.br = br; v.bt = bt;
    v.exmr = exmr; v.exrw = exrw; v.exwa = exwa; v.memmr = memmr; v.memwa = memwa;
    return v;
  endfunction

  task automatic apply(input in_t v);
    idRs = v.rs; idRt = v.rt; idUsesRs = v.urs; idUsesRt = v.urt;
    idBranch = v.br; branchTaken = v.bt; exMemRead = v.exmr; exRegWrite = v.exrw;
    exWriteAddress = v.exwa; memMemRead = v.memmr; memWriteAddress = v.memwa;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic pc, input logic ifid,
                         input logic hz, input logic fl);
    chk({name, ".pcWrite"},   {31'd0, pcWrite},   {31'd0, pc});
    chk({name, ".ifIdWrite"}, {31'd0, ifIdWrite}, {31'd0, ifid});
    chk({name, ".hazard"},    {31'd0, hazard},    {31'd0, hz});
    chk({name, ".ifIdFlush"}, {31'd0, ifIdFlush}, {31'd0, fl});
  endtask

  // Inputs change just after a rising edge; outputs are sampled mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply('0);
    next_cycle();
    reset = 1'b0;
  endtask

  in_t  IDLE, LU8, BLEX9, R0, BT;
  vec_t tbl[12];
  logic [31:0] exp_stall, exp_flush;

  initial begin
    IDLE  = '0;
    LU8   = mk(5'd8, 5'd3, 1, 0, 0, 0, 1, 1, 5'd8, 0, 5'd0);
    BLEX9 = mk(5'd4, 5'd9, 0, 1, 1, 0, 1, 1, 5'd9, 0, 5'd0);
    R0    = mk(5'd0, 5'd0, 1, 0, 0, 0, 1, 1, 5'd0, 0, 5'd0);
    BT    = mk(5'd1, 5'd2, 1, 1, 1, 1, 0, 0, 5'd0, 0, 5'd0);

    tbl[0]  = '{"idle",            IDLE,                                                1, 1, 0, 0};
    tbl[1]  = '{"loaduse_rs",      LU8,                                                 0, 0, 1, 0};
    tbl[2]  = '{"loaduse_rt_unused", mk(5'd1, 5'd8, 1, 0, 0, 0, 1, 1, 5'd8, 0, 5'd0),   1, 1, 0, 0};
    tbl[3]  = '{"loaduse_r0",      R0,                                                  1, 1, 0, 0};
    tbl[4]  = '{"branch_alu",      mk(5'd5, 5'd6, 1, 1, 1, 0, 0, 1, 5'd5, 0, 5'd0),     0, 0, 1, 0};
    tbl[5]  = '{"alu_no_branch",   mk(5'd5, 5'd6, 1, 1, 0, 0, 0, 1, 5'd5, 0, 5'd0),     1, 1, 0, 0};
    tbl[6]  = '{"branch_load_mem", mk(5'd1, 5'd7, 1, 1, 1, 0, 0, 0, 5'd2, 1, 5'd7),     0, 0, 1, 0};
    tbl[7]  = '{"mem_masked_by_ex", mk(5'd1, 5'd7, 0, 1, 1, 0, 0, 0, 5'd7, 1, 5'd7),    1, 1, 0, 0};
    tbl[8]  = '{"taken_flush",     BT,                                                  1, 1, 0, 1};
    tbl[9]  = '{"taken_vs_loaduse", mk(5'd8, 5'd3, 1, 0, 0, 1, 1, 1, 5'd8, 0, 5'd0),    0, 0, 1, 0};
    tbl[10] = '{"mem_load_no_branch", mk(5'd7, 5'd2, 1, 0, 0, 0, 0, 0, 5'd0, 1, 5'd7),  1, 1, 0, 0};
    tbl[11] = '{"taken_vs_branch_alu", mk(5'd5, 5'd6, 0, 1, 1, 1, 0, 1, 5'd6, 0, 5'd0), 0, 0, 1, 0};

    reset = 1'b1; sc_reset = 1'b1; sc_inc = 1'b0;
    apply('0);
    next_cycle();

    // Reset with a live load-use pattern: detection must be suppressed.
    apply(LU8);
    #3;
    chk_out("reset_out", 1, 1, 0, 0);
    next_cycle();
    chk("reset_stall", stallCount, 32'd0);
    chk("reset_flush", flushCount, 32'd0);
    reset = 1'b0;

    // Table vectors, all single-cycle so the FSM stays in RUN.
    apply('0);
    next_cycle();
    exp_stall = 0; exp_flush = 0;
    foreach (tbl[k]) begin
      apply(tbl[k].i);
      #3;
      chk_out(tbl[k].name, tbl[k].pc, tbl[k].ifid, tbl[k].hz, tbl[k].fl);
      chk({tbl[k].name, ".stallCount"}, stallCount, exp_stall);
      chk({tbl[k].name, ".flushCount"}, flushCount, exp_flush);
      exp_stall += {31'd0, tbl[k].hz};
      exp_flush += {31'd0, tbl[k].fl};
      next_cycle();
    end
    apply('0);
    #3;
    chk("table_stall_total", stallCount, exp_stall);
    chk("table_flush_total", flushCount, exp_flush);

    // Load-use: single bubble then resume.
    do_reset();
    apply(LU8);
    #3;
    chk_out("lu_c1", 0, 0, 1, 0);
    next_cycle();
    apply(IDLE);
    #3;
    chk_out("lu_c2", 1, 1, 0, 0);
    chk("lu_stall", stallCount, 32'd1);

    // Branch on load in EX: two bubbles, second held with inputs cleared.
    do_reset();
    apply(BLEX9);
    #3;
    chk_out("blex_c1", 0, 0, 1, 0);
    next_cycle();
    apply(mk(5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0));
    #3;
    chk_out("blex_hold", 0, 0, 1, 0);
    next_cycle();
    apply(IDLE);
    #3;
    chk_out("blex_c3", 1, 1, 0, 0);
    chk("blex_stall", stallCount, 32'd2);
    chk("blex_flush", flushCount, 32'd0);

    // Register zero never matches.
    do_reset();
    apply(R0);
    #3;
    chk_out("r0", 1, 1, 0, 0);
    next_cycle();
    apply(IDLE);
    #3;
    chk("r0_stall", stallCount, 32'd0);

    // Stall beats flush, then flush on the following clean cycle.
    do_reset();
    apply(mk(5'd8, 5'd3, 1, 0, 1, 1, 1, 1, 5'd8, 0, 5'd0));
    apply(mk(5'd8, 5'd3, 1, 0, 0, 1, 1, 1, 5'd8, 0, 5'd0));
    #3;
    chk_out("sim_c1", 0, 0, 1, 0);
    next_cycle();
    apply(BT);
    #3;
    chk_out("sim_c2", 1, 1, 0, 1);
    next_cycle();
    apply(IDLE);
    #3;
    chk("sim_flush", flushCount, 32'd1);
    chk("sim_stall", stallCount, 32'd1);

    // Reset during HOLD aborts the second bubble.
    do_reset();
    apply(BLEX9);
    #3;
    chk_out("rh_c1", 0, 0, 1, 0);
    next_cycle();
    reset = 1'b1;
    apply(IDLE);
    #3;
    chk_out("rh_reset", 1, 1, 0, 0);
    next_cycle();
    reset = 1'b0;
    #3;
    chk_out("rh_after", 1, 1, 0, 0);
    chk("rh_stall", stallCount, 32'd0);
    chk("rh_flush", flushCount, 32'd0);
    next_cycle();
    apply(LU8);
    #3;
    chk_out("rh_fresh", 0, 0, 1, 0);
    next_cycle();
    apply(IDLE);
    #3;
    chk_out("rh_fresh_run", 1, 1, 0, 0);

    // Saturation on a 2-bit counter: 1,2,3 then stuck at 3.
    sc_reset = 1'b0;
    sc_inc   = 1'b1;
    for (int unsigned n = 1; n <= 5; n++) begin
      next_cycle();
      chk($sformatf("sat_step%0d", n), {30'd0, sc_count}, (n >= 3) ? 32'd3 : n);
    end
    sc_inc = 1'b0;
    next_cycle();
    chk("sat_idle", {30'd0, sc_count}, 32'd3);
    sc_reset = 1'b1;
    next_cycle();
    chk("sat_reset", {30'd0, sc_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
